// File: rtl/horner_pkg.sv
// Shared definitions for the Horner packet sequencer: FSM states,
// header field positions and default sizing.
package horner_pkg;

  // Default sizing of the sequencer.
  localparam int MAX_DEG_DEF = 7;
  localparam int NX_W_DEF    = 16;

  // Header beat layout: degree in the low nibble, x count in the upper half-word.
  localparam int HDR_DEG_LSB = 0;
  localparam int HDR_DEG_W   = 4;
  localparam int HDR_NX_LSB  = 16;

  // Coefficient index width seen by the core (index 0 = highest order).
  localparam int COEF_IDX_W  = 3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_COEF  = 3'd1,
    ST_XWAIT = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // A header is unusable when its degree exceeds what the core supports or
  // when it announces no x samples at all.
  function automatic logic hdr_is_bad(input logic [HDR_DEG_W-1:0] deg,
                                      input logic                 nx_zero,
                                      input int                   max_deg);
    return (int'(deg) > max_deg) || nx_zero;
  endfunction

endpackage

// File: rtl/horner_seq_axis_out_reg.sv
// Single-entry master-side output register. Holds one result with its
// tlast until the downstream consumer takes it.
module axis_out_reg
  import horner_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic             last_i,
  input  logic             m_tready_i,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
  output logic             free_o
);

  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             last_q;

  // Load a new result, or retire the held one when the consumer accepts it.
  // The sequencer never loads while an unaccepted result is held, so load
  // simply takes priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (valid_q && m_tready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  // The slot is free for a new result either when empty or when the held
  // result is being taken in this very cycle.
  assign free_o     = !valid_q || m_tready_i;
  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/horner_seq.sv
// Packet sequencer in front of the Horner evaluation core. Parses the
// header, streams coefficients into the core, feeds x samples one at a time
// and returns each result on the master stream with tlast.
module horner_seq
  import horner_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int OUT_W   = 8,
  parameter int MAX_DEG = MAX_DEG_DEF,
  parameter int NX_W    = NX_W_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // slave stream
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  // master stream
  output logic [OUT_W-1:0]      m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  // core interface
  output logic                  core_coef_we,
  output logic [COEF_IDX_W-1:0] core_coef_idx,
  output logic [DATA_W-1:0]     core_coef_data,
  output logic                  core_start,
  output logic [DATA_W-1:0]     core_x,
  input  logic                  core_done,
  input  logic [OUT_W-1:0]      core_result,
  // status
  input  logic                  err_clr,
  output logic                  err_hdr,
  output logic                  err_len,
  output logic                  busy
);

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  state_e                  state_q;
  logic                    rdy_en_q;      // low only until the first clock after reset
  logic [COEF_IDX_W-1:0]   deg_q;         // polynomial degree of current packet
  logic [COEF_IDX_W-1:0]   coef_cnt_q;    // next coefficient index
  logic [NX_W-1:0]         nx_last_q;     // NX-1, index of the final x beat
  logic [NX_W-1:0]         x_cnt_q;       // index of the next x beat
  logic                    x_tlast_q;     // in-flight x arrived with tlast
  logic                    x_final_q;     // in-flight x is beat NX
  logic                    coef_we_q;
  logic [COEF_IDX_W-1:0]   coef_idx_q;
  logic [DATA_W-1:0]       coef_data_q;
  logic                    start_q;
  logic [DATA_W-1:0]       x_q;
  logic                    err_hdr_q;
  logic                    err_len_q;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [HDR_DEG_W-1:0]    hdr_deg;
  logic [NX_W-1:0]         hdr_nx;
  logic                    hdr_bad;
  logic                    s_hs;
  logic                    s_ready_state;
  logic                    x_is_final;
  logic                    out_free;
  logic                    out_load;
  logic                    out_last;

  assign hdr_deg    = s_tdata[HDR_DEG_LSB +: HDR_DEG_W];
  assign hdr_nx     = s_tdata[HDR_NX_LSB +: NX_W];
  assign hdr_bad    = hdr_is_bad(hdr_deg, (hdr_nx == '0), MAX_DEG);
  assign x_is_final = (x_cnt_q == nx_last_q);

  // Ready per state. In XWAIT the next x is only taken when the output
  // register can absorb its result, which is what keeps results from being
  // overwritten before the consumer has taken them.
  always_comb begin
    s_ready_state = 1'b0;
    unique case (state_q)
      ST_HDR, ST_COEF, ST_DRAIN: s_ready_state = 1'b1;
      ST_XWAIT:                  s_ready_state = out_free;
      default:                   s_ready_state = 1'b0;
    endcase
  end

  assign s_tready = rdy_en_q & s_ready_state;
  assign s_hs     = s_tvalid & s_tready;

  // A core result is only meaningful while we are waiting for it; a stray
  // done after reset or in any other state is ignored.
  assign out_load = (state_q == ST_RUN) && core_done;
  assign out_last = x_tlast_q | x_final_q;

  // ---------------------------------------------------------------------
  // Sequencer FSM with its counters, core strobes and sticky errors
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_HDR;
      rdy_en_q    <= 1'b0;
      deg_q       <= '0;
      coef_cnt_q  <= '0;
      nx_last_q   <= '0;
      x_cnt_q     <= '0;
      x_tlast_q   <= 1'b0;
      x_final_q   <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_idx_q  <= '0;
      coef_data_q <= '0;
      start_q     <= 1'b0;
      x_q         <= '0;
      err_hdr_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      coef_we_q <= 1'b0;
      start_q   <= 1'b0;

      unique case (state_q)
        ST_HDR: begin
          if (s_hs) begin
            if (hdr_bad) begin
              // A bad header that also ends the packet needs no draining.
              err_hdr_q <= 1'b1;
              state_q   <= s_tlast ? ST_HDR : ST_DRAIN;
            end else if (s_tlast) begin
              err_len_q <= 1'b1;
            end else begin
              deg_q      <= hdr_deg[COEF_IDX_W-1:0];
              nx_last_q  <= hdr_nx - NX_W'(1);
              coef_cnt_q <= '0;
              x_cnt_q    <= '0;
              state_q    <= ST_COEF;
            end
          end
        end

        ST_COEF: begin
          if (s_hs) begin
            if (s_tlast) begin
              // Truncated packet: abandon it without touching the core.
              err_len_q <= 1'b1;
              state_q   <= ST_HDR;
            end else begin
              coef_we_q   <= 1'b1;
              coef_idx_q  <= coef_cnt_q;
              coef_data_q <= s_tdata;
              coef_cnt_q  <= coef_cnt_q + COEF_IDX_W'(1);
              if (coef_cnt_q == deg_q) begin
                state_q <= ST_XWAIT;
              end
            end
          end
        end

        ST_XWAIT: begin
          if (s_hs) begin
            x_q       <= s_tdata;
            start_q   <= 1'b1;
            x_tlast_q <= s_tlast;
            x_final_q <= x_is_final;
            x_cnt_q   <= x_cnt_q + NX_W'(1);
            // tlast must coincide exactly with the final x beat.
            if (s_tlast != x_is_final) begin
              err_len_q <= 1'b1;
            end
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (core_done) begin
            if (x_tlast_q) begin
              state_q <= ST_HDR;
            end else if (x_final_q) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_XWAIT;
            end
          end
        end

        ST_DRAIN: begin
          if (s_hs && s_tlast) begin
            state_q <= ST_HDR;
          end
        end

        default: state_q <= ST_HDR;
      endcase

      // Clearing wins over any error raised in the same cycle.
      if (err_clr) begin
        err_hdr_q <= 1'b0;
        err_len_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Master-side output register
  // ---------------------------------------------------------------------
  axis_out_reg #(
    .OUT_W (OUT_W)
  ) u_out_reg (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load_i     (out_load),
    .data_i     (core_result),
    .last_i     (out_last),
    .m_tready_i (m_tready),
    .m_tdata_o  (m_tdata),
    .m_tvalid_o (m_tvalid),
    .m_tlast_o  (m_tlast),
    .free_o     (out_free)
  );

  assign core_coef_we   = coef_we_q;
  assign core_coef_idx  = coef_idx_q;
  assign core_coef_data = coef_data_q;
  assign core_start     = start_q;
  assign core_x         = x_q;
  assign err_hdr        = err_hdr_q;
  assign err_len        = err_len_q;
  assign busy           = (state_q != ST_HDR);

endmodule

// File: doc/horner_seq.md
# horner_seq

Packet sequencer between the slave AXI-Stream input and the Horner evaluation core. It parses a per-packet header, loads the polynomial coefficients into the core, and feeds x samples one at a time. It captures each 8-bit result into a single-entry output register and drives the master stream with tlast and tready backpressure, so the top level no longer ignores s_tlast and m_tready.

## Interface
- DATA_W, 64, slave tdata width
- OUT_W, 8, result and master tdata width
- MAX_DEG, 7, highest supported polynomial degree
- NX_W, 16, x-count field width

Ports:
- aclk  in  1  single clock for the whole block
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  DATA_W  header, coefficient or x beat
- s_tvalid  in  1  slave valid
- s_tready  out  1  slave ready
- s_tlast  in  1  end of input packet
- m_tdata  out  OUT_W  result
- m_tvalid  out  1  master valid
- m_tready  in  1  master ready
- m_tlast  out  1  last result of packet
- core_coef_we  out  1  coefficient write strobe
- core_coef_idx  out  3  coefficient index, 0 = highest order
- core_coef_data  out  DATA_W  coefficient value
- core_start  out  1  one-cycle start pulse
- core_x  out  DATA_W  x operand, stable from start until done
- core_done  in  1  one-cycle result-valid pulse
- core_result  in  OUT_W  result, valid with core_done
- err_clr  in  1  clears sticky errors
- err_hdr  out  1  sticky flag: bad header
- err_len  out  1  sticky flag: tlast mismatch
- busy  out  1  high whenever state is not HDR

## Operation
- Header beat fields:
  - s_tdata[3:0] = degree D.
  - s_tdata[31:16] = NX, the number of x samples.
  - Other bits are ignored.
- Packet layout: header, then D+1 coefficient beats (highest order first), then NX x beats. tlast belongs on the last x beat.
- FSM states and transitions:
  - HDR: s_tready=1. Accept the header.
  - A header with D>MAX_DEG or NX=0 sets err_hdr and goes to DRAIN. If that header beat also carries tlast, stay in HDR instead.
  - A valid header goes to COEF.
  - COEF: s_tready=1. Each beat pulses core_coef_we with the next index. After index D, go to XWAIT.
  - XWAIT: s_tready = !m_tvalid || m_tready. On accept, register core_x, pulse core_start and go to RUN.
  - RUN: s_tready=0. On core_done, load core_result into the output register and set m_tvalid.
    - If it was the last x, go to HDR.
    - Otherwise go to XWAIT.
  - DRAIN: s_tready=1. Discard beats until the tlast handshake, then go to HDR.
- tlast rules:
  - tlast on a header or coefficient beat: err_len, return to HDR, no output, core not started.
  - tlast on x beat k<NX: that x is processed, its result carries m_tlast, err_len is set, and the packet ends.
  - No tlast on x beat NX: its result carries m_tlast, err_len is set, then DRAIN.
- Output register:
  - m_tdata, m_tvalid and m_tlast hold until m_tready.
  - A new result never overwrites an unaccepted one. This is guaranteed by the XWAIT ready gating.
- err_clr has priority over a same-cycle error set; the clear wins.

## Timing
- Reset values: all outputs 0, including s_tready, m_tvalid, m_tdata, m_tlast, all core_* outputs, err_hdr, err_len and busy. State is HDR.
- s_tready rises the first cycle after reset deassertion.
- Coefficient beat handshake at cycle t gives core_coef_we=1 at t+1, with registered idx and data.
- x handshake at cycle t gives core_start=1 at t+1. core_x is held until core_done.
- core_done at cycle u gives m_tvalid=1 at u+1.
- The next x handshake may coincide with the m_tready handshake of the previous result.
- Throughput is one x per (core latency + 2) cycles.
- Count widths:
  - Coefficient counter: 3 bits.
  - x counter: NX_W bits, compared against NX-1. There is no wrap, because NX=0 is rejected.
- Reset mid-packet or mid-RUN: everything returns to reset values immediately. A core_done arriving after reset is ignored because the state is HDR.

## Structure
- Shared package `horner_pkg`:
  - State enum (HDR, COEF, XWAIT, RUN, DRAIN).
  - Header field bit positions.
  - MAX_DEG and NX_W defaults.
- One natural sub-module, `axis_out_reg`: the single-entry master output register with load and ready logic.
- The FSM and counters stay in `horner_seq`.

## Test plan
- Valid packet, two results:
  - Stimulus: header D=2, NX=2; coefficients 3, 5, 7; x=1 then x=2 with tlast; core model computes mod 256; m_tready=1.
  - Required response: core_coef_idx 0,1,2 written; results 15 then 29; m_tlast only on 29; err flags 0.
- Backpressure:
  - Stimulus: same packet with m_tready=0 for 10 cycles after the first result.
  - Required response: m_tdata stays 15 throughout, and the second x is not accepted until the first result is taken.
- Bad header:
  - Stimulus: header D=9, then 4 junk beats ending in tlast.
  - Required response: err_hdr=1, all 4 beats consumed, no core_coef_we and no m_tvalid; the next valid packet processes normally.
- Early tlast:
  - Stimulus: NX=3 with tlast on x beat 2.
  - Required response: two results, the second with m_tlast; err_len=1; the next header is accepted.
- Missing tlast:
  - Stimulus: NX=1 with no tlast on the x beat, followed by 2 extra beats, the last of which has tlast.
  - Required response: one result with m_tlast; the extra beats are drained; err_len=1.
- Reset during RUN:
  - Stimulus: assert aresetn=0 while the core is busy, then a late core_done.
  - Required response: all outputs 0 and state HDR; the late core_done produces no m_tvalid.
